sr_pulse_gen: RTL and testbench
===============================

SR_PULSE_GEN -- requirements
Module: sr_pulse_gen

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive identical synchronized samples required to accept a new level; legal range 1..65535.
REQ-002 Port clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 Port notrst  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
REQ-004 Port set_btn  input  1  raw, asynchronous, bouncy set button.
REQ-005 Port rst_btn  input  1  raw, asynchronous, bouncy reset button.
REQ-006 Port s  output  1  one-cycle set pulse for the downstream SR/clocked-SR latch.
REQ-007 Port r  output  1  one-cycle reset pulse for the downstream SR/clocked-SR latch.
REQ-008 Port set_lvl  output  1  debounced level of set_btn.
REQ-009 Port rst_lvl  output  1  debounced level of rst_btn.
REQ-010 Port err  output  1  one-cycle pulse flagging a suppressed simultaneous set/reset request.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Each channel SHALL hold a counter of width clog2(DB_CYCLES+1) and a stable level register.
REQ-013 A synchronized sample equal to the stable level SHALL clear that channel's counter to 0.
REQ-014 A sample differing from the stable level SHALL increment the counter; on the DB_CYCLES-th consecutive differing sample the stable level SHALL toggle and the counter SHALL clear in the same edge.
REQ-015 Latency: a clean input change SHALL appear on *_lvl at the (2+DB_CYCLES)-th posedge after it is first sampled.
REQ-016 With DB_CYCLES=1 the stable level SHALL follow the synchronized sample with one cycle of lag.
REQ-017 s SHALL be 1 for exactly one cycle, in the cycle following a 0->1 transition of set_lvl; r likewise for rst_lvl.
REQ-018 1->0 transitions of set_lvl/rst_lvl SHALL generate no pulse.
REQ-019 If set_lvl and rst_lvl both rise in the same cycle, s and r SHALL both stay 0 and err SHALL pulse for one cycle.
REQ-020 A rising edge on one channel while the other level is already high SHALL still produce its pulse; s and r SHALL never be 1 in the same cycle.
REQ-021 s, r, err SHALL be registered outputs, glitch-free.

Reset
REQ-022 While notrst=0: synchronizers, counters, set_lvl, rst_lvl, s, r, err SHALL be 0, taking effect immediately without a clock.
REQ-023 Reset mid-debounce SHALL discard partial counts; after release the full 2+DB_CYCLES delay applies again.
REQ-024 A button held high across reset release SHALL be treated as a fresh 0->1 transition and produce one pulse.

Structure
REQ-025 Package sr_pulse_pkg SHALL hold the DB_CYCLES default constant and the counter-width function.
REQ-026 Per-channel synchronizer+counter+level logic SHALL be one sub-module, debounce, instantiated twice.

Verification (DB_CYCLES=4)
REQ-027 set_btn 0->1 clean, held 20 cycles -> set_lvl=1 at posedge 6, s=1 only during cycle 7, r=err=0 throughout.
REQ-028 set_btn toggles 1,0,1,0 at 2-cycle intervals then held 1 -> set_lvl rises only 6 edges after final rise; exactly one s pulse.
REQ-029 set_btn and rst_btn rise on the same edge, held -> s=r=0 throughout; err=1 for exactly one cycle.
REQ-030 set_btn held high, then rst_btn rises -> one r pulse, no s, err=0.
REQ-031 notrst pulled low after 2 differing samples, set_btn kept 1 -> all outputs 0 at once; after release set_lvl rises at posedge 6, one s pulse.
REQ-032 set_btn 1->0 after stable high -> set_lvl falls after 6 edges; s, r, err stay 0.

Source files
------------

// File: rtl/sr_pulse_pkg.sv
// Shared constants and helpers for the SR pulse generator.
// It holds the default debounce length and the width function for the debounce counter.
package sr_pulse_pkg;

    localparam int DB_CYCLES_DEF = 16;

    // The counter must be able to hold values up to and including DB_CYCLES.
    function automatic int cnt_width(input int db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/sr_pulse_gen_debounce.sv
// Debounces one button channel: a two-flop synchronizer feeds a run-length counter.
// The stable level changes only after DB_CYCLES consecutive samples that differ from it.
module debounce
    import sr_pulse_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic notrst,
    input  logic btn,
    output logic lvl
);

    localparam int CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Stage p0/p1: bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge notrst) begin
        if (!notrst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: count consecutive disagreeing samples; toggle and clear together on the last one.
    always_ff @(posedge clk or negedge notrst) begin
        if (!notrst) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (sync_p1 == lvl) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            lvl <= ~lvl;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sr_pulse_gen.sv
// Turns two bouncy buttons into clean one-cycle set/reset pulses for a downstream SR latch.
// A request where both channels rise in the same cycle is suppressed and flagged on err.
module sr_pulse_gen
    import sr_pulse_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic notrst,
    input  logic set_btn,
    input  logic rst_btn,
    output logic s,
    output logic r,
    output logic set_lvl,
    output logic rst_lvl,
    output logic err
);

    logic set_hist_p0;
    logic rst_hist_p0;
    logic set_rise;
    logic rst_rise;

    debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_set_db (
        .clk   (clk),
        .notrst(notrst),
        .btn   (set_btn),
        .lvl   (set_lvl)
    );

    debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_rst_db (
        .clk   (clk),
        .notrst(notrst),
        .btn   (rst_btn),
        .lvl   (rst_lvl)
    );

    always_comb begin
        set_rise = set_lvl & ~set_hist_p0;
        rst_rise = rst_lvl & ~rst_hist_p0;
    end

    // Stage p0: remember last level, register pulses so they are glitch-free.
    always_ff @(posedge clk or negedge notrst) begin
        if (!notrst) begin
            set_hist_p0 <= 1'b0;
            rst_hist_p0 <= 1'b0;
            s           <= 1'b0;
            r           <= 1'b0;
            err         <= 1'b0;
        end else begin
            set_hist_p0 <= set_lvl;
            rst_hist_p0 <= rst_lvl;
            s           <= set_rise & ~rst_rise;
            r           <= rst_rise & ~set_rise;
            err         <= set_rise & rst_rise;
        end
    end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed self-checking bench for sr_pulse_gen with DB_CYCLES=4.
// Each observation is {set_lvl, rst_lvl, s, r, err}; edge k is the k-th posedge after a stimulus change.
module tb_sr_pulse_gen;

    logic clk;
    logic notrst;
    logic set_btn;
    logic rst_btn;
    logic s;
    logic r;
    logic set_lvl;
    logic rst_lvl;
    logic err;

    int n_chk  = 0;
    int n_pass = 0;

    sr_pulse_gen #(
        .DB_CYCLES(4)
    ) dut (
        .clk    (clk),
        .notrst (notrst),
        .set_btn(set_btn),
        .rst_btn(rst_btn),
        .s      (s),
        .r      (r),
        .set_lvl(set_lvl),
        .rst_lvl(rst_lvl),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        notrst  = 1'b0;
        set_btn = 1'b0;
        rst_btn = 1'b0;
        repeat (2) @(negedge clk);
        notrst = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        notrst  = 1'b0;
        set_btn = 1'b0;
        rst_btn = 1'b0;
        #1;
        obs = {set_lvl, rst_lvl, s, r, err};
        n_chk++;
        if (obs !== 5'b00000) $display("FAIL reset_initial got %b want %b", obs, 5'b00000);
        else n_pass++;
        set_btn = 1'b1;
        rst_btn = 1'b1;
        repeat (8) @(negedge clk);
        obs = {set_lvl, rst_lvl, s, r, err};
        n_chk++;
        if (obs !== 5'b00000) $display("FAIL reset_held got %b want %b", obs, 5'b00000);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_clean_rise();
        logic [4:0] obs;
        logic [4:0] exp;
        do_reset();
        set_btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            obs = {set_lvl, rst_lvl, s, r, err};
            exp = {(k >= 6), 1'b0, (k == 7), 1'b0, 1'b0};
            n_chk++;
            if (obs !== exp) $display("FAIL clean_rise k=%0d got %b want %b", k, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [4:0] obs;
        logic [4:0] exp;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            set_btn = (k <= 8) ? (((k - 1) / 2) % 2 == 0) : 1'b1;
            @(negedge clk);
            obs = {set_lvl, rst_lvl, s, r, err};
            exp = {(k >= 14), 1'b0, (k == 15), 1'b0, 1'b0};
            n_chk++;
            if (obs !== exp) $display("FAIL bounce k=%0d got %b want %b", k, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] obs;
        logic [4:0] exp;
        do_reset();
        set_btn = 1'b1;
        rst_btn = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            obs = {set_lvl, rst_lvl, s, r, err};
            exp = {(k >= 6), (k >= 6), 1'b0, 1'b0, (k == 7)};
            n_chk++;
            if (obs !== exp) $display("FAIL simultaneous k=%0d got %b want %b", k, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_rst_while_set();
        logic [4:0] obs;
        logic [4:0] exp;
        do_reset();
        set_btn = 1'b1;
        repeat (10) @(negedge clk);
        obs = {set_lvl, rst_lvl, s, r, err};
        n_chk++;
        if (obs !== 5'b10000) $display("FAIL set_settled got %b want %b", obs, 5'b10000);
        else n_pass++;
        rst_btn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            obs = {set_lvl, rst_lvl, s, r, err};
            exp = {1'b1, (k >= 6), 1'b0, (k == 7), 1'b0};
            n_chk++;
            if (obs !== exp) $display("FAIL rst_while_set k=%0d got %b want %b", k, obs, exp);
            else n_pass++;
        end
        // Asynchronous reset: clear without waiting for a clock edge.
        #2;
        notrst = 1'b0;
        #1;
        obs = {set_lvl, rst_lvl, s, r, err};
        n_chk++;
        if (obs !== 5'b00000) $display("FAIL async_reset got %b want %b", obs, 5'b00000);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [4:0] obs;
        logic [4:0] exp;
        do_reset();
        set_btn = 1'b1;
        repeat (4) @(negedge clk);
        notrst = 1'b0;
        #1;
        obs = {set_lvl, rst_lvl, s, r, err};
        n_chk++;
        if (obs !== 5'b00000) $display("FAIL reset_mid_assert got %b want %b", obs, 5'b00000);
        else n_pass++;
        repeat (2) @(negedge clk);
        notrst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            obs = {set_lvl, rst_lvl, s, r, err};
            exp = {(k >= 6), 1'b0, (k == 7), 1'b0, 1'b0};
            n_chk++;
            if (obs !== exp) $display("FAIL reset_mid k=%0d got %b want %b", k, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_fall();
        logic [4:0] obs;
        logic [4:0] exp;
        do_reset();
        set_btn = 1'b1;
        repeat (10) @(negedge clk);
        obs = {set_lvl, rst_lvl, s, r, err};
        n_chk++;
        if (obs !== 5'b10000) $display("FAIL fall_pre got %b want %b", obs, 5'b10000);
        else n_pass++;
        set_btn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            obs = {set_lvl, rst_lvl, s, r, err};
            exp = {(k < 6), 1'b0, 1'b0, 1'b0, 1'b0};
            n_chk++;
            if (obs !== exp) $display("FAIL fall k=%0d got %b want %b", k, obs, exp);
            else n_pass++;
        end
    endtask

    initial begin
        notrst  = 1'b0;
        set_btn = 1'b0;
        rst_btn = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_rise();
        test_bounce();
        test_simultaneous();
        test_rst_while_set();
        test_reset_mid();
        test_fall();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
